// File: rtl/rom_map_pkg.sv
// Shared ROM map definitions: region layout, FSM state encoding and default fill byte.
// Used by the upload readback path and reusable by the download selectors.
package rom_map_pkg;
    localparam int REGION_COUNT = 9;
    localparam int REGION_SIZE  = 16384;
    localparam int ADDR_W       = 25;
    localparam int OFFS_W       = $clog2(REGION_SIZE);
    localparam int SEL_W        = 4;

    localparam logic [ADDR_W-1:0] REGION_BASE [REGION_COUNT] = '{
        25'h00000, 25'h04000, 25'h08000,
        25'h10000, 25'h14000, 25'h18000,
        25'h20000, 25'h24000, 25'h28000
    };

    localparam logic [7:0] DEFAULT_FILL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAITLAT,
        CAPTURE
    } rb_state_t;
endpackage

// File: rtl/rom_region_decode.sv
// Combinational byte address -> {valid, region index, offset within region}.
module rom_region_decode
    import rom_map_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic [SEL_W-1:0]  index,
    output logic [OFFS_W-1:0] offset
);

    // Regions are 16 KB aligned, so only the bits above the offset take part in the match.
    always_comb begin
        valid  = 1'b0;
        index  = '0;
        offset = addr[OFFS_W-1:0];
        for (int i = 0; i < REGION_COUNT; i++) begin
            if (addr[ADDR_W-1:OFFS_W] == REGION_BASE[i][ADDR_W-1:OFFS_W]) begin
                valid = 1'b1;
                index = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/rom_readback.sv
// Serves HPS upload byte reads from the ROM regions, with a uniform fetch latency
// for mapped and unmapped addresses, plus a running session checksum.
//   state   | meaning
//   IDLE    | waiting for an RD strobe while UPLOAD is high
//   ISSUE   | pulse RAM_RD (mapped only), load latency counter
//   WAITLAT | count down the RAM read latency
//   CAPTURE | returned byte visible on DATA_OUT, WAIT low
module rom_readback
    import rom_map_pkg::*;
#(
    parameter int         RD_LAT = 1,
    parameter logic [7:0] FILL   = DEFAULT_FILL
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              UPLOAD,
    input  logic              RD,
    input  logic [ADDR_W-1:0] IOCTL_ADDR,
    output logic [7:0]        DATA_OUT,
    output logic              WAIT,
    output logic [SEL_W-1:0]  RAM_SEL,
    output logic [OFFS_W-1:0] RAM_ADDR,
    output logic              RAM_RD,
    input  logic [7:0]        RAM_DATA,
    output logic [15:0]       SUM,
    output logic              ERR
);

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

    rb_state_t         state, state_nxt;
    logic [1:0]        lat_cnt;
    logic              map_valid;
    logic              upload_q;
    logic              dec_valid;
    logic [SEL_W-1:0]  dec_index;
    logic [OFFS_W-1:0] dec_offset;
    logic [7:0]        fetch_byte;
    logic              accept;
    logic              capture_now;

    rom_region_decode u_decode (
        .addr   (IOCTL_ADDR),
        .valid  (dec_valid),
        .index  (dec_index),
        .offset (dec_offset)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (RD && UPLOAD) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAITLAT;
            WAITLAT: if (lat_cnt <= 2'd1) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Dropping the session abandons any fetch in flight.
        if (!UPLOAD) state_nxt = IDLE;
    end

    assign WAIT        = (state == ISSUE) || (state == WAITLAT);
    assign RAM_RD      = (state == ISSUE) && map_valid;
    assign accept      = (state == IDLE) && RD && UPLOAD;
    assign capture_now = (state == WAITLAT) && (state_nxt == CAPTURE);
    assign fetch_byte  = map_valid ? RAM_DATA : FILL;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            map_valid <= 1'b0;
            upload_q  <= 1'b0;
            RAM_SEL   <= '0;
            RAM_ADDR  <= '0;
            DATA_OUT  <= '0;
            SUM       <= '0;
            ERR       <= 1'b0;
        end else begin
            state    <= state_nxt;
            upload_q <= UPLOAD;

            if (accept) begin
                map_valid <= dec_valid;
                RAM_SEL   <= dec_index;
                RAM_ADDR  <= dec_offset;
            end

            if (state == ISSUE)
                lat_cnt <= LAT_INIT;
            else if (state == WAITLAT && lat_cnt != 2'd0)
                lat_cnt <= lat_cnt - 2'd1;

            // The byte is registered on the edge entering CAPTURE so it is valid as WAIT falls.
            if (capture_now) begin
                DATA_OUT <= fetch_byte;
                SUM      <= SUM + {8'h00, fetch_byte};
            end

            if (UPLOAD && !upload_q) begin
                SUM <= '0;
                ERR <= 1'b0;
            end else if (RD && UPLOAD && state != IDLE) begin
                ERR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rom_readback.sv
// Directed bench for rom_readback: one instance with RD_LAT=1, one with RD_LAT=3,
// each backed by a behavioural ROM with the matching read latency.
module tb_rom_readback;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        upload = 1'b0, rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic        upload3 = 1'b0, rd3 = 1'b0;
    logic [24:0] ioctl_addr3 = '0;

    logic [7:0]  data_out, data_out3;
    logic        wait1, wait3;
    logic [3:0]  ram_sel, ram_sel3;
    logic [13:0] ram_addr, ram_addr3;
    logic        ram_rd, ram_rd3;
    logic [7:0]  ram_data = 8'h00, ram_data3 = 8'h00;
    logic [15:0] sum, sum3;
    logic        err, err3;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rom_readback #(.RD_LAT(1)) dut (
        .CLK(clk), .RESET(reset), .UPLOAD(upload), .RD(rd), .IOCTL_ADDR(ioctl_addr),
        .DATA_OUT(data_out), .WAIT(wait1), .RAM_SEL(ram_sel), .RAM_ADDR(ram_addr),
        .RAM_RD(ram_rd), .RAM_DATA(ram_data), .SUM(sum), .ERR(err)
    );

    rom_readback #(.RD_LAT(3)) dut3 (
        .CLK(clk), .RESET(reset), .UPLOAD(upload3), .RD(rd3), .IOCTL_ADDR(ioctl_addr3),
        .DATA_OUT(data_out3), .WAIT(wait3), .RAM_SEL(ram_sel3), .RAM_ADDR(ram_addr3),
        .RAM_RD(ram_rd3), .RAM_DATA(ram_data3), .SUM(sum3), .ERR(err3)
    );

    function automatic logic [7:0] rom_byte(input logic [3:0] sel, input logic [13:0] offs);
        if (sel == 4'd3 && offs == 14'h0010) return 8'h5A;
        if (sel == 4'd0 && offs == 14'h0001) return 8'h01;
        if (sel == 4'd8 && offs == 14'h0000) return 8'h3C;
        return 8'hEE;
    endfunction

    // Latency-1 ROM: data appears on the edge that samples RAM_RD.
    always @(posedge clk)
        if (ram_rd) ram_data <= rom_byte(ram_sel, ram_addr);

    // Latency-3 ROM: data appears two edges after the edge that samples RAM_RD.
    logic [2:0]  v3 = '0;
    logic [23:0] d3 = '0;
    always @(posedge clk) begin
        v3 <= {v3[1:0], ram_rd3};
        d3 <= {d3[15:0], rom_byte(ram_sel3, ram_addr3)};
        if (v3[1]) ram_data3 <= d3[15:8];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Full read on the RD_LAT=1 instance; returns with the FSM back in IDLE.
    task automatic do_read(input logic [24:0] a);
        rd = 1'b1;
        ioctl_addr = a;
        tick();
        rd = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        #1;
        chk("rst_data", data_out, 8'h00);
        chk("rst_wait", wait1, 1'b0);
        chk("rst_ramrd", ram_rd, 1'b0);
        chk("rst_sel", ram_sel, 4'd0);
        chk("rst_addr", ram_addr, 14'h0);
        chk("rst_sum", sum, 16'h0);
        chk("rst_err", err, 1'b0);
        #13 reset = 1'b0;
        tick();
        upload = 1'b1;
        tick();

        // Mapped read, latency 1
        rd = 1'b1; ioctl_addr = 25'h10010;
        tick();
        rd = 1'b0;
        chk("m_c1_wait", wait1, 1'b1);
        chk("m_c1_ramrd", ram_rd, 1'b1);
        chk("m_c1_sel", ram_sel, 4'd3);
        chk("m_c1_addr", ram_addr, 14'h0010);
        tick();
        chk("m_c2_wait", wait1, 1'b1);
        chk("m_c2_ramrd", ram_rd, 1'b0);
        tick();
        chk("m_c3_wait", wait1, 1'b0);
        chk("m_c3_data", data_out, 8'h5A);
        chk("m_c3_sum", sum, 16'h005A);
        tick();

        // Unmapped read
        rd = 1'b1; ioctl_addr = 25'h0C000;
        tick();
        rd = 1'b0;
        chk("u_c1_wait", wait1, 1'b1);
        chk("u_c1_ramrd", ram_rd, 1'b0);
        tick();
        chk("u_c2_wait", wait1, 1'b1);
        chk("u_c2_ramrd", ram_rd, 1'b0);
        tick();
        chk("u_c3_wait", wait1, 1'b0);
        chk("u_c3_data", data_out, 8'hFF);
        chk("u_c3_sum", sum, 16'h0159);
        chk("u_c3_err", err, 1'b0);
        tick();

        // RD while UPLOAD low: ignored, no error
        upload = 1'b0; rd = 1'b1; ioctl_addr = 25'h10010;
        tick();
        rd = 1'b0;
        chk("noup_wait", wait1, 1'b0);
        chk("noup_ramrd", ram_rd, 1'b0);
        chk("noup_err", err, 1'b0);
        upload = 1'b1;
        tick();
        chk("rise_sum", sum, 16'h0);

        // UPLOAD dropped in WAITLAT
        rd = 1'b1; ioctl_addr = 25'h10010;
        tick();
        rd = 1'b0;
        tick();
        chk("drop_c2_wait", wait1, 1'b1);
        upload = 1'b0;
        tick();
        chk("drop_wait", wait1, 1'b0);
        chk("drop_data", data_out, 8'hFF);
        chk("drop_sum", sum, 16'h0);
        tick();
        chk("drop_ramrd", ram_rd, 1'b0);
        chk("drop_data2", data_out, 8'hFF);
        chk("drop_wait2", wait1, 1'b0);

        // UPLOAD rise together with RD: fetch proceeds
        upload = 1'b1; rd = 1'b1; ioctl_addr = 25'h00001;
        tick();
        rd = 1'b0;
        chk("rr_c1_ramrd", ram_rd, 1'b1);
        chk("rr_c1_sel", ram_sel, 4'd0);
        chk("rr_c1_sum", sum, 16'h0);
        tick();
        tick();
        chk("rr_c3_data", data_out, 8'h01);
        chk("rr_c3_sum", sum, 16'h0001);

        // RD during CAPTURE: error, ignored
        rd = 1'b1; ioctl_addr = 25'h28000;
        tick();
        rd = 1'b0;
        chk("cap_err", err, 1'b1);
        chk("cap_wait", wait1, 1'b0);
        chk("cap_ramrd", ram_rd, 1'b0);
        tick();
        chk("cap_ramrd2", ram_rd, 1'b0);
        chk("cap_data", data_out, 8'h01);

        // Checksum wrap sequence over unmapped addresses
        upload = 1'b0;
        tick();
        upload = 1'b1;
        tick();
        chk("clr_sum", sum, 16'h0);
        chk("clr_err", err, 1'b0);
        for (int i = 0; i < 256; i++) begin
            case (i % 4)
                0: do_read(25'h0C000);
                1: do_read(25'h1FFFFFF);
                2: do_read(25'h2C000);
                default: do_read(25'h1C000);
            endcase
        end
        chk("s256_sum", sum, 16'hFF00);
        chk("s256_data", data_out, 8'hFF);
        chk("s256_err", err, 1'b0);
        do_read(25'h00001);
        chk("s257_sum", sum, 16'hFF01);
        upload = 1'b0;
        tick();
        upload = 1'b1;
        tick();
        chk("s_rise_sum", sum, 16'h0);

        // Reset pulsed in ISSUE
        rd = 1'b1; ioctl_addr = 25'h10010;
        tick();
        rd = 1'b0;
        chk("ri_ramrd", ram_rd, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("ri_data", data_out, 8'h00);
        chk("ri_wait", wait1, 1'b0);
        chk("ri_ramrd0", ram_rd, 1'b0);
        chk("ri_sel", ram_sel, 4'd0);
        chk("ri_addr", ram_addr, 14'h0);
        chk("ri_sum", sum, 16'h0);
        #3 reset = 1'b0;
        tick();
        rd = 1'b1; ioctl_addr = 25'h28000;
        tick();
        rd = 1'b0;
        chk("pr_c1_ramrd", ram_rd, 1'b1);
        chk("pr_c1_sel", ram_sel, 4'd8);
        tick();
        chk("pr_c2_wait", wait1, 1'b1);
        tick();
        chk("pr_c3_data", data_out, 8'h3C);
        chk("pr_c3_sum", sum, 16'h003C);
        chk("pr_c3_wait", wait1, 1'b0);

        // Latency 3 with a second RD two cycles after the first
        upload3 = 1'b1;
        tick();
        rd3 = 1'b1; ioctl_addr3 = 25'h28000;
        tick();
        rd3 = 1'b0;
        chk("l3_c1_ramrd", ram_rd3, 1'b1);
        chk("l3_c1_sel", ram_sel3, 4'd8);
        chk("l3_c1_wait", wait3, 1'b1);
        tick();
        rd3 = 1'b1; ioctl_addr3 = 25'h10010;
        tick();
        rd3 = 1'b0;
        chk("l3_c3_err", err3, 1'b1);
        chk("l3_c3_ramrd", ram_rd3, 1'b0);
        chk("l3_c3_wait", wait3, 1'b1);
        tick();
        chk("l3_c4_wait", wait3, 1'b1);
        chk("l3_c4_data", data_out3, 8'h00);
        tick();
        chk("l3_c5_wait", wait3, 1'b0);
        chk("l3_c5_data", data_out3, 8'h3C);
        chk("l3_c5_sum", sum3, 16'h003C);
        tick();
        chk("l3_c6_ramrd", ram_rd3, 1'b0);
        chk("l3_c6_wait", wait3, 1'b0);
        chk("l3_c6_sel", ram_sel3, 4'd8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rom_readback.md
ROM_READBACK -- requirements
Module: rom_readback

Interface
REQ-001 Parameter RD_LAT, default 1: RAM read latency in clocks, from the RAM_RD edge to RAM_DATA valid; legal range 1..3.
REQ-002 Parameter FILL, default 8'hFF: byte returned for unmapped addresses.
REQ-003 CLK  in  1  single clock; all logic rising-edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 UPLOAD  in  1  HPS upload session active.
REQ-006 RD  in  1  one-cycle read strobe from HPS, one per byte.
REQ-007 IOCTL_ADDR  in  25  byte address of the requested byte, valid with RD.
REQ-008 DATA_OUT  out  8  byte returned to HPS.
REQ-009 WAIT  out  1  HPS stall; high while a fetch is in flight.
REQ-010 RAM_SEL  out  4  ROM region index 0..8, valid with RAM_RD.
REQ-011 RAM_ADDR  out  14  byte offset within the region.
REQ-012 RAM_RD  out  1  one-cycle read pulse to the selected ROM read port.
REQ-013 RAM_DATA  in  8  read data from the selected ROM.
REQ-014 SUM  out  16  running byte checksum of the current session.
REQ-015 ERR  out  1  sticky protocol-error flag.

Function
REQ-016 Address map, 16 KB regions: index 0..8 at bases 0x00000, 0x04000, 0x08000, 0x10000, 0x14000, 0x18000, 0x20000, 0x24000, 0x28000; every other address is unmapped.
REQ-017 For a mapped address: RAM_SEL = region index; RAM_ADDR = IOCTL_ADDR[13:0].
REQ-018 The FSM has exactly the states IDLE, ISSUE, WAITLAT and CAPTURE.
REQ-019 IDLE: on RD=1 with UPLOAD=1, latch the address and decode it, then go to ISSUE.
REQ-020 ISSUE: WAIT=1; RAM_RD=1 for exactly one cycle only if the address is mapped; load the latency counter with RD_LAT.
REQ-021 WAITLAT: WAIT=1; decrement the counter; go to CAPTURE when the counter reaches zero.
REQ-022 CAPTURE: register DATA_OUT from RAM_DATA, or FILL if unmapped; SUM += byte (mod 2^16); WAIT=0; return to IDLE.
REQ-023 Timing is uniform for mapped and unmapped addresses:
- RD sampled at cycle 0.
- WAIT high in cycles 1 through RD_LAT+1.
- DATA_OUT valid and WAIT low from cycle RD_LAT+2.
REQ-024 DATA_OUT holds its last value outside CAPTURE updates.
REQ-025 RD while WAIT=1: ignored (no new fetch, the current fetch is undisturbed) and ERR set.
REQ-026 RD while UPLOAD=0: ignored, ERR unchanged.
REQ-027 UPLOAD falling mid-fetch:
- FSM returns to IDLE next cycle and WAIT=0.
- DATA_OUT and SUM are unchanged, no further RAM_RD is issued.
REQ-028 UPLOAD rising edge clears SUM and ERR; if RD is also high in that same cycle, the fetch proceeds normally.
REQ-029 RD coinciding with CAPTURE is treated as RD-while-WAIT (REQ-025).
REQ-030 Address 0x1FFFFFF and other out-of-range addresses return FILL without error.

Reset
REQ-031 RESET=1 asynchronously forces the following, regardless of state (including mid-fetch):
- state IDLE;
- DATA_OUT=8'h00, WAIT=0, RAM_RD=0, RAM_SEL=0, RAM_ADDR=0;
- SUM=0, ERR=0, latency counter 0.
REQ-032 The first RD after reset release behaves per REQ-019..023.

Structure
REQ-033 Shared package rom_map_pkg holds: region count (9), region size (16 KB), region base constants, FSM state enum, default FILL.
REQ-034 One sub-module, rom_region_decode: combinational address -> {valid, index, offset}, reusable by the download selectors.

Verification
REQ-035 RD_LAT=1, RAM preloaded with 0x5A at region 3 offset 0x0010; RD at addr 0x10010 -> RAM_RD pulse with SEL=3, ADDR=0x0010; WAIT high 2 cycles; DATA_OUT=0x5A at cycle 3; SUM=0x005A.
REQ-036 RD at 0x0C000 (unmapped) -> no RAM_RD; DATA_OUT=0xFF at cycle 3; SUM increases by 0xFF.
REQ-037 RD_LAT=3; RD at 0x28000, then second RD two cycles later -> second RD ignored, ERR=1; first data delivered at cycle 5.
REQ-038 Sequence: read 256 bytes each 0xFF -> SUM=0xFF00; then one more 0x01 -> SUM=0xFF01; next UPLOAD rise -> SUM=0.
REQ-039 UPLOAD dropped in WAITLAT -> WAIT=0 next cycle, DATA_OUT and SUM unchanged.
REQ-040 RESET pulsed in ISSUE -> all outputs at reset values within the same cycle; a subsequent read completes correctly.
